fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_ctrl_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the FIFO write-side arbiter.
package fifo_ctrl_pkg;

  localparam int DSIZE   = 140;
  localparam int NREQ    = 4;
  localparam int BURST_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request bit searching upward from last_idx+1,
// wrapping, with last_idx itself taking lowest priority. Purely combinational.
module rr_priority_pick #(
  parameter int NREQ = fifo_ctrl_pkg::NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_idx,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDXW = $clog2(NREQ);

  // cand[k] is the k-th position after last_idx; NREQ is a power of two so
  // truncation to IDXW bits is the wrap-around.
  logic [IDXW-1:0] cand [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = last_idx + IDXW'(gi + 1);
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NREQ producers take bounded bursts of writes
// into a single FIFO write port, with a wrapping count of words written.
module fifo_wr_arbiter #(
  parameter int DSIZE     = fifo_ctrl_pkg::DSIZE,
  parameter int NREQ      = fifo_ctrl_pkg::NREQ,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_w_enable,
  output logic [DSIZE-1:0]        data_to_fifo,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    grant_active,
  output logic [31:0]             wr_count
);

  import fifo_ctrl_pkg::*;

  localparam int IDXW = $clog2(NREQ);

  arb_state_t          state_reg;
  logic [IDXW-1:0]     last_grant_reg;
  logic [IDXW-1:0]     grant_id_reg;
  logic [BURST_W-1:0]  burst_cnt_reg;
  logic [31:0]         wr_count_reg;

  logic [DSIZE-1:0]    req_words [NREQ];
  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic                in_grant;
  logic                holder_valid;
  logic                xfer;
  logic                burst_last;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
      assign req_words[gi] = req_data[gi*DSIZE +: DSIZE];
    end
  endgenerate

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req      (req_valid),
    .last_idx (last_grant_reg),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Reset masks the write path in the same cycle so a mid-burst reset drops
  // the pending word instead of committing it.
  assign in_grant     = (state_reg == GRANT) && !rst;
  assign holder_valid = req_valid[grant_id_reg];
  assign xfer         = in_grant && holder_valid && !fifo_full;
  assign burst_last   = (burst_cnt_reg + BURST_W'(1)) == BURST_W'(MAX_BURST);

  assign fifo_w_enable = xfer;
  assign grant_active  = in_grant;
  assign grant_id      = grant_id_reg;
  assign wr_count      = wr_count_reg;
  assign data_to_fifo  = in_grant ? req_words[grant_id_reg] : '0;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (grant_id_reg == IDXW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDXW'(NREQ - 1);
      grant_id_reg   <= '0;
      burst_cnt_reg  <= '0;
      wr_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg     <= GRANT;
            grant_id_reg  <= pick_idx;
            burst_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + BURST_W'(1);
            wr_count_reg  <= wr_count_reg + 32'd1;
          end
          // A full FIFO with the holder still valid simply stalls here.
          if ((xfer && burst_last) || !holder_valid) begin
            state_reg      <= IDLE;
            last_grant_reg <= grant_id_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (4 requesters, 140-bit words).
module tb_fifo_wr_arbiter;

  localparam int DW = 140;
  localparam int NR = 4;

  logic            clk_in = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_w_enable;
  logic [DW-1:0]   data_to_fifo;
  logic [1:0]      grant_id;
  logic            grant_active;
  logic [31:0]     wr_count;

  fifo_wr_arbiter #(.DSIZE(DW), .NREQ(NR), .MAX_BURST(4)) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_w_enable (fifo_w_enable),
    .data_to_fifo  (data_to_fifo),
    .grant_id      (grant_id),
    .grant_active  (grant_active),
    .wr_count      (wr_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        full;
    logic        wen;
    logic        act;
    logic [1:0]  gid;
    logic [31:0] cnt;
  } vec_t;

  vec_t        vecs[$];
  logic [DW-1:0] pat [NR];
  int unsigned model_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // One row per clock: inputs for the cycle and outputs expected before the edge.
  task automatic add(input logic r, input logic [3:0] v, input logic f,
                     input logic w, input logic a, input logic [1:0] g);
    vec_t t;
    t.rst = r; t.vld = v; t.full = f; t.wen = w; t.act = a; t.gid = g;
    t.cnt = model_cnt;
    vecs.push_back(t);
    if (r) model_cnt = 0;
    else if (w) model_cnt = model_cnt + 1;
  endtask

  task automatic burst(input logic [3:0] v, input logic [1:0] g, input int n);
    for (int i = 0; i < n; i++) add(1'b0, v, 1'b0, 1'b1, 1'b1, g);
  endtask

  task automatic idle(input logic [3:0] v, input logic [1:0] g);
    add(1'b0, v, 1'b0, 1'b0, 1'b0, g);
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    logic [3:0]    exp_rdy;
    logic [DW-1:0] exp_data;

    pat[0] = {{17{8'hC3}}, 4'h1};
    pat[1] = {{17{8'h96}}, 4'h6};
    pat[2] = {{17{8'h5A}}, 4'h5};
    pat[3] = {{17{8'h0F}}, 4'h3};
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pat[i];

    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk_in);

    // reset state
    add(1, 4'h0, 0, 0, 0, 2'd0);
    // all four valid: bursts of 4 in order 0,1,2,3,0 with one bubble each
    idle(4'hF, 2'd0);
    burst(4'hF, 2'd0, 4); idle(4'hF, 2'd0);
    burst(4'hF, 2'd1, 4); idle(4'hF, 2'd1);
    burst(4'hF, 2'd2, 4); idle(4'hF, 2'd2);
    burst(4'hF, 2'd3, 4); idle(4'hF, 2'd3);
    burst(4'hF, 2'd0, 4); idle(4'h0, 2'd0); idle(4'h0, 2'd0);
    // only requester 2: 4, bubble, 4, bubble, 2, then drop
    idle(4'h4, 2'd0);
    burst(4'h4, 2'd2, 4); idle(4'h4, 2'd2);
    burst(4'h4, 2'd2, 4); idle(4'h4, 2'd2);
    burst(4'h4, 2'd2, 2);
    add(0, 4'h0, 0, 0, 1, 2'd2);
    idle(4'h0, 2'd2);
    // fifo_full for 3 cycles after the 2nd write
    idle(4'h1, 2'd2);
    burst(4'h1, 2'd0, 2);
    for (int i = 0; i < 3; i++) add(0, 4'h1, 1, 0, 1, 2'd0);
    burst(4'h1, 2'd0, 2);
    idle(4'h0, 2'd0);
    // holder drops after 1 write while req 3 waits
    idle(4'hA, 2'd0);
    burst(4'hA, 2'd1, 1);
    add(0, 4'h8, 0, 0, 1, 2'd1);
    idle(4'h8, 2'd1);
    burst(4'h8, 2'd3, 2);
    add(0, 4'h0, 0, 0, 1, 2'd3);
    idle(4'h0, 2'd3);
    // reset mid-burst of requester 2, then requester 0 wins first
    idle(4'h4, 2'd3);
    burst(4'h4, 2'd2, 2);
    add(1, 4'h4, 0, 0, 0, 2'd2);
    idle(4'hF, 2'd0);
    burst(4'hF, 2'd0, 1);
    add(0, 4'h0, 0, 0, 1, 2'd0);
    idle(4'h0, 2'd0);

    foreach (vecs[i]) begin
      @(negedge clk_in);
      rst       = vecs[i].rst;
      req_valid = vecs[i].vld;
      fifo_full = vecs[i].full;
      #1;
      exp_rdy  = vecs[i].wen ? (4'b0001 << vecs[i].gid) : 4'b0000;
      exp_data = vecs[i].act ? pat[vecs[i].gid] : '0;
      chk($sformatf("v%0d fifo_w_enable", i), DW'(fifo_w_enable), DW'(vecs[i].wen));
      chk($sformatf("v%0d req_ready", i),     DW'(req_ready),     DW'(exp_rdy));
      chk($sformatf("v%0d grant_active", i),  DW'(grant_active),  DW'(vecs[i].act));
      chk($sformatf("v%0d grant_id", i),      DW'(grant_id),      DW'(vecs[i].gid));
      chk($sformatf("v%0d data_to_fifo", i),  data_to_fifo,       exp_data);
      chk($sformatf("v%0d wr_count", i),      DW'(wr_count),      DW'(vecs[i].cnt));
      $display("vec %0d rst=%b vld=%b full=%b -> wen=%b rdy=%b act=%b gid=%0d cnt=%0d",
               i, rst, req_valid, fifo_full, fifo_w_enable, req_ready, grant_active,
               grant_id, wr_count);
    end

    // wr_count wrap: preload all ones, then a single write
    @(negedge clk_in);
    force dut.wr_count_reg = 32'hFFFF_FFFF;
    rst = 1'b0; req_valid = 4'b0001; fifo_full = 1'b0;
    @(negedge clk_in);
    release dut.wr_count_reg;
    #1;
    chk("wrap preload", DW'(wr_count), DW'(32'hFFFF_FFFF));
    chk("wrap write enable", DW'(fifo_w_enable), DW'(1'b1));
    $display("wrap pre: wen=%b cnt=%0h", fifo_w_enable, wr_count);
    @(negedge clk_in);
    req_valid = 4'b0000;
    #1;
    chk("wrap count", DW'(wr_count), DW'(32'h0));
    chk("wrap grant held", DW'(grant_active), DW'(1'b1));
    $display("wrap post: act=%b cnt=%0h", grant_active, wr_count);
    @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
